// File: rtl/p4_router_dequeue_scheduler.sv
// Packet-granular dequeue scheduler: round-robin over eligible egress ports, strict priority within a port.
// Optional starvation guard enabled by defining P4_ROUTER_DQ_SCHED_STARVE_GUARD_EN.
//
// state | meaning
// IDLE  | searching for an eligible port; registers the selection into the grant
// GRANT | grant_valid offered and held stable until grant_ready
// BUSY  | grant accepted; waits for pkt_done or watchdog expiry
module p4_router_dequeue_scheduler #(
  parameter int NUM_EGR_PORTS           = 4,
  parameter int NUM_QUEUES_PER_EGR_PORT = 8,
  parameter int TIMEOUT_CYCLES          = 4096,
  parameter int STARVE_LIMIT            = 16,
  localparam int NUM_QUEUES = NUM_EGR_PORTS * NUM_QUEUES_PER_EGR_PORT,
  localparam int QL = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1,
  localparam int PL = (NUM_EGR_PORTS > 1) ? $clog2(NUM_EGR_PORTS) : 1
) (
  input  logic                     clk,
  input  logic                     aresetn,
  input  logic                     enable,
  input  logic [NUM_EGR_PORTS-1:0] port_enable,
  input  logic [NUM_EGR_PORTS-1:0] egr_buf_ready,
  input  logic [NUM_QUEUES-1:0]    queue_nonempty,
  output logic                     grant_valid,
  input  logic                     grant_ready,
  output logic [QL-1:0]            grant_queue,
  output logic [PL-1:0]            grant_port,
  input  logic                     pkt_done,
  output logic                     busy,
  output logic                     timeout_err,
  output logic [31:0]              grant_cnt
);
  localparam int Q   = NUM_QUEUES_PER_EGR_PORT;
  localparam int LQW = (Q > 1) ? $clog2(Q) : 1;
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  if (NUM_EGR_PORTS < 1 || Q < 1 || TIMEOUT_CYCLES < 2 || STARVE_LIMIT < 1) begin : g_bad_params
    $error("p4_router_dequeue_scheduler: illegal parameter value");
  end

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BUSY} state_t;

  state_t             r_state;
  logic [PL-1:0]      r_rr_ptr;
  logic               r_grant_valid;
  logic [QL-1:0]      r_grant_queue;
  logic [PL-1:0]      r_grant_port;
  logic               r_busy;
  logic               r_timeout_err;
  logic [31:0]        r_grant_cnt;
  logic [WDW-1:0]     r_wd;

  logic [NUM_EGR_PORTS-1:0] w_port_elig;
  logic                     w_any_elig;
  logic [PL-1:0]            w_sel_port;
  logic [LQW-1:0]           w_sel_local;
  logic [QL-1:0]            w_sel_queue;
  logic                     w_accept;

`ifdef P4_ROUTER_DQ_SCHED_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] r_starve [NUM_EGR_PORTS];
  logic          w_bypass;
  logic          w_grant_hi;
`endif

  always_comb begin
    logic v_pfound;
    logic v_qfound;
    int   v_base;
    w_port_elig = '0;
    w_sel_port  = '0;
    w_sel_local = '0;
    v_pfound    = 1'b0;
    v_qfound    = 1'b0;
    for (int p = 0; p < NUM_EGR_PORTS; p++)
      w_port_elig[p] = enable && port_enable[p] && egr_buf_ready[p] && (|queue_nonempty[p*Q +: Q]);
    w_any_elig = |w_port_elig;
    for (int i = 0; i < NUM_EGR_PORTS; i++) begin
      int v_idx;
      v_idx = (int'(r_rr_ptr) + i) % NUM_EGR_PORTS;
      if (!v_pfound && w_port_elig[v_idx]) begin
        v_pfound   = 1'b1;
        w_sel_port = PL'(v_idx);
      end
    end
    v_base = int'(w_sel_port) * Q;
    for (int q = 0; q < Q; q++) begin
      if (!v_qfound && queue_nonempty[v_base + q]) begin
        v_qfound    = 1'b1;
        w_sel_local = LQW'(q);
      end
    end
`ifdef P4_ROUTER_DQ_SCHED_STARVE_GUARD_EN
    // A starved port gets its lowest-priority non-empty queue once.
    if (int'(r_starve[w_sel_port]) >= STARVE_LIMIT) begin
      for (int q = 0; q < Q; q++)
        if (queue_nonempty[v_base + q]) w_sel_local = LQW'(q);
    end
`endif
    w_sel_queue = QL'(v_base + int'(w_sel_local));
  end

  assign w_accept = (r_state == S_GRANT) && grant_ready;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_valid <= 1'b0;
      r_grant_queue <= '0;
      r_grant_port  <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_grant_cnt   <= '0;
      r_wd          <= '0;
    end else begin
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_elig) begin
            r_grant_queue <= w_sel_queue;
            r_grant_port  <= w_sel_port;
            r_grant_valid <= 1'b1;
            r_state       <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (grant_ready) begin
            r_grant_valid <= 1'b0;
            r_busy        <= 1'b1;
            r_rr_ptr      <= PL'((int'(r_grant_port) + 1) % NUM_EGR_PORTS);
            r_grant_cnt   <= r_grant_cnt + 32'd1;
            r_wd          <= '0;
            r_state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (pkt_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_wd == WD_LAST) begin
            r_timeout_err <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= S_IDLE;
          end else begin
            r_wd <= r_wd + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef P4_ROUTER_DQ_SCHED_STARVE_GUARD_EN
  always_comb begin
    int v_local;
    int v_base;
    v_base     = int'(r_grant_port) * Q;
    v_local    = int'(r_grant_queue) - v_base;
    w_grant_hi = (v_local == 0);
    w_bypass   = 1'b0;
    for (int q = 0; q < Q; q++)
      if (q > v_local && queue_nonempty[v_base + q]) w_bypass = 1'b1;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      for (int p = 0; p < NUM_EGR_PORTS; p++) r_starve[p] <= '0;
    end else if (w_accept) begin
      if (!w_grant_hi)
        r_starve[r_grant_port] <= '0;
      else if (w_bypass && int'(r_starve[r_grant_port]) < STARVE_LIMIT)
        r_starve[r_grant_port] <= r_starve[r_grant_port] + 1'b1;
    end
  end
`endif

  assign grant_valid = r_grant_valid;
  assign grant_queue = r_grant_queue;
  assign grant_port  = r_grant_port;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign grant_cnt   = r_grant_cnt;
endmodule

// File: tb/tb_p4_router_dequeue_scheduler.sv
// Scoreboard bench for p4_router_dequeue_scheduler (4 ports x 8 queues, 16-cycle watchdog).
module tb_p4_router_dequeue_scheduler;
  localparam int NP = 4;
  localparam int NQ = 32;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b1;
  logic [NP-1:0] port_enable = '1;
  logic [NP-1:0] egr_buf_ready = '1;
  logic [NQ-1:0] queue_nonempty = '0;
  logic          grant_valid;
  logic          grant_ready = 1'b0;
  logic [4:0]    grant_queue;
  logic [1:0]    grant_port;
  logic          pkt_done = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic [31:0]   grant_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct { int q; int p; } exp_t;
  exp_t sb[$];

  p4_router_dequeue_scheduler #(
    .NUM_EGR_PORTS(NP), .NUM_QUEUES_PER_EGR_PORT(8), .TIMEOUT_CYCLES(16), .STARVE_LIMIT(16)
  ) dut (
    .clk(clk), .aresetn(aresetn), .enable(enable), .port_enable(port_enable),
    .egr_buf_ready(egr_buf_ready), .queue_nonempty(queue_nonempty),
    .grant_valid(grant_valid), .grant_ready(grant_ready), .grant_queue(grant_queue),
    .grant_port(grant_port), .pkt_done(pkt_done), .busy(busy),
    .timeout_err(timeout_err), .grant_cnt(grant_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every accepted grant must match the oldest expectation.
  always @(negedge clk) begin
    if (aresetn && grant_valid && grant_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_grant", grant_queue, -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("grant_queue", grant_queue, e.q);
        check("grant_port", grant_port, e.p);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("wait_busy_bound", 0, 1);
  endtask

  task automatic do_grant(input int q, input int p, input bit last);
    bit ok;
    sb.push_back('{q: q, p: p});
    wait_busy(ok);
    if (!ok) return;
    if (last) queue_nonempty = '0;
    pkt_done = 1'b1;
    tick();
    pkt_done = 1'b0;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    int pulses;
    int first;
    bit ok;

    do_reset();
    check("rst_grant_valid", grant_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_cnt", grant_cnt, 0);
    check("rst_grant_queue", grant_queue, 0);
    check("rst_timeout_err", timeout_err, 0);

    // Single queue: port 0 prio 5, one cycle of arbitration latency.
    queue_nonempty[5] = 1'b1;
    tick();
    check("t1_valid_latency", grant_valid, 1);
    check("t1_queue_direct", grant_queue, 5);
    grant_ready = 1'b1;
    do_grant(5, 0, 1);
    check("t1_grant_cnt", grant_cnt, 1);
    check("t1_busy_after_done", busy, 0);

    // Round-robin between ports 0 and 1 from a fresh pointer.
    do_reset();
    queue_nonempty[2] = 1'b1;
    queue_nonempty[9] = 1'b1;
    do_grant(2, 0, 0);
    do_grant(9, 1, 0);
    do_grant(2, 0, 0);
    do_grant(9, 1, 1);
    check("t2_grant_cnt", grant_cnt, 4);

    // Strict priority within port 1: queue 11 never wins against queue 8.
    queue_nonempty[8]  = 1'b1;
    queue_nonempty[11] = 1'b1;
    do_grant(8, 1, 0);
    do_grant(8, 1, 0);
    do_grant(8, 1, 0);
    do_grant(8, 1, 1);
    check("t3_grant_cnt", grant_cnt, 8);

    // Egress buffer backpressure, then an irrevocable offer.
    grant_ready = 1'b0;
    egr_buf_ready[0] = 1'b0;
    queue_nonempty[3] = 1'b1;
    repeat (4) tick();
    check("t4_no_grant_bp", grant_valid, 0);
    egr_buf_ready[0] = 1'b1;
    tick();
    check("t4_valid_after_ready", grant_valid, 1);
    check("t4_queue", grant_queue, 3);
    queue_nonempty = '0;
    enable = 1'b0;
    tick();
    check("t4_offer_held", grant_valid, 1);
    check("t4_queue_held", grant_queue, 3);
    enable = 1'b1;
    grant_ready = 1'b1;
    do_grant(3, 0, 1);
    check("t4_grant_cnt", grant_cnt, 9);

    // Watchdog release: pulse exactly once, 16 cycles after busy rises.
    queue_nonempty[3] = 1'b1;
    sb.push_back('{q: 3, p: 0});
    wait_busy(ok);
    queue_nonempty = '0;
    pulses = 0;
    first = -1;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (timeout_err) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    check("t5_timeout_pulses", pulses, 1);
    check("t5_timeout_cycle", first, 16);
    check("t5_busy_released", busy, 0);
    queue_nonempty[3] = 1'b1;
    do_grant(3, 0, 1);
    check("t5_grant_cnt", grant_cnt, 11);

    // Asynchronous reset while in GRANT.
    grant_ready = 1'b0;
    queue_nonempty[5] = 1'b1;
    tick();
    check("t6_in_grant", grant_valid, 1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_async_valid", grant_valid, 0);
    check("t6_async_busy", busy, 0);
    check("t6_async_cnt", grant_cnt, 0);
    queue_nonempty = '0;
    tick();
    aresetn = 1'b1;
    tick();

    check("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "bench time limit");
  end
endmodule
